// File: rtl/keypad_mode_ctrl.sv
// Purpose : keypad mode/operand-entry controller; turns scanner presses into a
//           STOPWATCH/ENTER_X/ENTER_Y/RESULT mode FSM, accumulates binary operands,
//           latches the operator and issues one-cycle command/start pulses.
// Latency : a press first sampled at edge N updates state/outputs at edge N+1;
//           pulses are high from N+1 to N+2.
// Backpressure: none; every key edge is acted on, and a held key is a single event.
//
// Ports:
//   i_clk           system clock, rising edge
//   i_rst           asynchronous reset, active-high
//   i_key_valid     scanner "pressed" level, high while a key is held
//   i_key_code[3:0] scanner key code, valid while i_key_valid=1
//   o_mode[1:0]     0=STOPWATCH 1=ENTER_X 2=ENTER_Y 3=RESULT
//   o_x[W-1:0]      operand X (binary)
//   o_y[W-1:0]      operand Y (binary)
//   o_op[1:0]       0=ADD 1=SUB 2=MUL 3=DIV
//   o_led_x         X confirmed
//   o_led_y         Y confirmed
//   o_calc_start    1-cycle pulse: operands/op valid, start calculator
//   o_sw_cmd_valid  1-cycle pulse: key forwarded to stopwatch
//   o_sw_cmd[3:0]   last forwarded key code
module keypad_mode_ctrl #(
    parameter int DIGITS       = 2,
    parameter int W            = 7,
    parameter int IDLE_TIMEOUT = 0
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_key_valid,
    input  logic [3:0]   i_key_code,
    output logic [1:0]   o_mode,
    output logic [W-1:0] o_x,
    output logic [W-1:0] o_y,
    output logic [1:0]   o_op,
    output logic         o_led_x,
    output logic         o_led_y,
    output logic         o_calc_start,
    output logic         o_sw_cmd_valid,
    output logic [3:0]   o_sw_cmd
);

    typedef enum logic [1:0] {
        ST_SW  = 2'd0,
        ST_EX  = 2'd1,
        ST_EY  = 2'd2,
        ST_RES = 2'd3
    } state_t;

    localparam int CW = $clog2(DIGITS + 1);
    // The idle counter only ever holds 0..IDLE_TIMEOUT-1.
    localparam int IW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
    localparam bit IDLE_EN = (IDLE_TIMEOUT > 0);
    localparam logic [CW-1:0] CNT_FULL  = CW'(DIGITS);
    localparam logic [IW-1:0] IDLE_LAST = IW'((IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0);

    // v*10 + d using shifts, truncated to W bits.
    function automatic logic [W-1:0] f_acc(input logic [W-1:0] v, input logic [3:0] d);
        return (v << 3) + (v << 1) + W'(d);
    endfunction

    // key history
    logic          r_kv_q;
    logic          r_kv_qq;
    logic [3:0]    r_kc_q;

    // architectural state
    state_t        r_state;
    logic [W-1:0]  r_x;
    logic [W-1:0]  r_y;
    logic [1:0]    r_op;
    logic          r_led_x;
    logic          r_led_y;
    logic          r_calc_start;
    logic          r_sw_cmd_valid;
    logic [3:0]    r_sw_cmd;
    logic [CW-1:0] r_cnt;
    logic [IW-1:0] r_idle;

    // next-state values
    state_t        w_state_n;
    logic [W-1:0]  w_x_n;
    logic [W-1:0]  w_y_n;
    logic [1:0]    w_op_n;
    logic          w_led_x_n;
    logic          w_led_y_n;
    logic          w_calc_start_n;
    logic          w_sw_cmd_valid_n;
    logic [3:0]    w_sw_cmd_n;
    logic [CW-1:0] w_cnt_n;
    logic [IW-1:0] w_idle_n;

    // key decode
    logic          w_key_evt;
    logic          w_is_digit;
    logic          w_is_op;
    logic          w_is_enter;
    logic [1:0]    w_op_code;

    assign w_key_evt  = r_kv_q & ~r_kv_qq;
    assign w_is_digit = (r_kc_q < 4'd10);
    assign w_is_op    = (r_kc_q >= 4'd10) && (r_kc_q <= 4'd13);
    assign w_is_enter = (r_kc_q == 4'd14);
    // codes 10..13 map to 0..3: low two bits minus 2, modulo 4
    assign w_op_code  = r_kc_q[1:0] - 2'd2;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_kv_q         <= 1'b0;
            r_kv_qq        <= 1'b0;
            r_kc_q         <= 4'd0;
            r_state        <= ST_SW;
            r_x            <= '0;
            r_y            <= '0;
            r_op           <= 2'd0;
            r_led_x        <= 1'b0;
            r_led_y        <= 1'b0;
            r_calc_start   <= 1'b0;
            r_sw_cmd_valid <= 1'b0;
            r_sw_cmd       <= 4'd0;
            r_cnt          <= '0;
            r_idle         <= '0;
        end else begin
            r_kv_q         <= i_key_valid;
            r_kv_qq        <= r_kv_q;
            r_kc_q         <= i_key_code;
            r_state        <= w_state_n;
            r_x            <= w_x_n;
            r_y            <= w_y_n;
            r_op           <= w_op_n;
            r_led_x        <= w_led_x_n;
            r_led_y        <= w_led_y_n;
            r_calc_start   <= w_calc_start_n;
            r_sw_cmd_valid <= w_sw_cmd_valid_n;
            r_sw_cmd       <= w_sw_cmd_n;
            r_cnt          <= w_cnt_n;
            r_idle         <= w_idle_n;
        end
    end

    always_comb begin
        w_state_n        = r_state;
        w_x_n            = r_x;
        w_y_n            = r_y;
        w_op_n           = r_op;
        w_led_x_n        = r_led_x;
        w_led_y_n        = r_led_y;
        w_calc_start_n   = 1'b0;
        w_sw_cmd_valid_n = 1'b0;
        w_sw_cmd_n       = r_sw_cmd;
        w_cnt_n          = r_cnt;
        w_idle_n         = r_idle;

        if (w_key_evt) begin
            case (r_state)
                ST_SW: begin
                    if (w_is_enter) begin
                        w_state_n = ST_EX;
                        w_x_n     = '0;
                        w_y_n     = '0;
                        w_cnt_n   = '0;
                        w_led_x_n = 1'b0;
                        w_led_y_n = 1'b0;
                        w_op_n    = 2'd0;
                    end else begin
                        w_sw_cmd_n       = r_kc_q;
                        w_sw_cmd_valid_n = 1'b1;
                    end
                end

                ST_EX: begin
                    if (w_is_digit) begin
                        // a full operand silently drops further digits
                        if (r_cnt < CNT_FULL) begin
                            w_x_n   = f_acc(r_x, r_kc_q);
                            w_cnt_n = r_cnt + CW'(1);
                        end
                    end else if (w_is_op) begin
                        w_op_n = w_op_code;
                    end else if (w_is_enter) begin
                        if (r_cnt != '0) begin
                            w_led_x_n = 1'b1;
                            w_cnt_n   = '0;
                            w_state_n = ST_EY;
                        end
                    end else begin
                        // CLEAR: first wipes the operand, second leaves entry mode
                        if (r_cnt != '0) begin
                            w_x_n   = '0;
                            w_cnt_n = '0;
                        end else begin
                            w_state_n = ST_SW;
                        end
                    end
                end

                ST_EY: begin
                    if (w_is_digit) begin
                        if (r_cnt < CNT_FULL) begin
                            w_y_n   = f_acc(r_y, r_kc_q);
                            w_cnt_n = r_cnt + CW'(1);
                        end
                    end else if (w_is_op) begin
                        w_op_n = w_op_code;
                    end else if (w_is_enter) begin
                        if (r_cnt != '0) begin
                            w_led_y_n      = 1'b1;
                            w_calc_start_n = 1'b1;
                            w_state_n      = ST_RES;
                        end
                    end else begin
                        if (r_cnt != '0) begin
                            w_y_n   = '0;
                            w_cnt_n = '0;
                        end else begin
                            // Back to X with the count saturated: X can be
                            // re-confirmed as-is, but new digits need a CLEAR first.
                            w_state_n = ST_EX;
                            w_led_x_n = 1'b0;
                            w_cnt_n   = CNT_FULL;
                        end
                    end
                end

                ST_RES: begin
                    if (w_is_enter) begin
                        w_state_n = ST_EX;
                        w_x_n     = '0;
                        w_y_n     = '0;
                        w_cnt_n   = '0;
                        w_led_x_n = 1'b0;
                        w_led_y_n = 1'b0;
                        w_op_n    = 2'd0;
                    end else if (!w_is_digit && !w_is_op) begin
                        w_state_n = ST_SW;
                        w_led_x_n = 1'b0;
                        w_led_y_n = 1'b0;
                    end
                end

                default: w_state_n = ST_SW;
            endcase
        end

        // Idle timer: a key event on the expiry edge takes priority and restarts it.
        if (IDLE_EN) begin
            if (w_key_evt || (w_state_n != r_state) || (r_state == ST_SW)) begin
                w_idle_n = '0;
            end else if (r_idle == IDLE_LAST) begin
                w_state_n = ST_SW;
                w_led_x_n = 1'b0;
                w_led_y_n = 1'b0;
                w_idle_n  = '0;
            end else begin
                w_idle_n = r_idle + IW'(1);
            end
        end
    end

    assign o_mode         = r_state;
    assign o_x            = r_x;
    assign o_y            = r_y;
    assign o_op           = r_op;
    assign o_led_x        = r_led_x;
    assign o_led_y        = r_led_y;
    assign o_calc_start   = r_calc_start;
    assign o_sw_cmd_valid = r_sw_cmd_valid;
    assign o_sw_cmd       = r_sw_cmd;

endmodule

// File: tb/tb_keypad_mode_ctrl.sv
// Testbench for keypad_mode_ctrl: a 2-digit instance with a 100-clock idle timeout
// and a 3-digit/10-bit instance without timeout. Expected values are queued when a
// step is driven and compared once the DUT has had time to respond.
module tb_keypad_mode_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       kv;
    logic [3:0] kc;
    logic       sel3;
    logic       kv_a;
    logic       kv_b;

    always #5 clk = ~clk;

    assign kv_a = kv & ~sel3;
    assign kv_b = kv & sel3;

    logic [1:0] mode_a, op_a, mode_b, op_b;
    logic [6:0] x_a, y_a;
    logic [9:0] x_b, y_b;
    logic       ledx_a, ledy_a, cs_a, swv_a, ledx_b, ledy_b, cs_b, swv_b;
    logic [3:0] swc_a, swc_b;

    keypad_mode_ctrl #(.DIGITS(2), .W(7), .IDLE_TIMEOUT(100)) dut (
        .i_clk(clk), .i_rst(rst), .i_key_valid(kv_a), .i_key_code(kc),
        .o_mode(mode_a), .o_x(x_a), .o_y(y_a), .o_op(op_a),
        .o_led_x(ledx_a), .o_led_y(ledy_a), .o_calc_start(cs_a),
        .o_sw_cmd_valid(swv_a), .o_sw_cmd(swc_a)
    );

    keypad_mode_ctrl #(.DIGITS(3), .W(10), .IDLE_TIMEOUT(0)) dut3 (
        .i_clk(clk), .i_rst(rst), .i_key_valid(kv_b), .i_key_code(kc),
        .o_mode(mode_b), .o_x(x_b), .o_y(y_b), .o_op(op_b),
        .o_led_x(ledx_b), .o_led_y(ledy_b), .o_calc_start(cs_b),
        .o_sw_cmd_valid(swv_b), .o_sw_cmd(swc_b)
    );

    // pulse counters, sampled well clear of both clock edges
    int calc_cnt = 0;
    int swv_cnt  = 0;
    always begin
        @(posedge clk);
        #2;
        if (cs_a)  calc_cnt++;
        if (swv_a) swv_cnt++;
    end

    localparam int S_MODE = 0, S_X = 1, S_Y = 2, S_OP = 3, S_LX = 4, S_LY = 5,
                   S_SWC = 6, S_CALC = 7, S_SWV = 8, S_MODE3 = 9, S_X3 = 10,
                   S_CS = 11, S_SWVL = 12;

    typedef struct {
        string tag;
        int    sel;
        int    val;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;

    function automatic int observe(input int sel);
        case (sel)
            S_MODE:  return int'(mode_a);
            S_X:     return int'(x_a);
            S_Y:     return int'(y_a);
            S_OP:    return int'(op_a);
            S_LX:    return int'(ledx_a);
            S_LY:    return int'(ledy_a);
            S_SWC:   return int'(swc_a);
            S_CALC:  return calc_cnt;
            S_SWV:   return swv_cnt;
            S_MODE3: return int'(mode_b);
            S_X3:    return int'(x_b);
            S_CS:    return int'(cs_a);
            S_SWVL:  return int'(swv_a);
            default: return -1;
        endcase
    endfunction

    task automatic exp_push(input string tag, input int sel, input int val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        int   obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.sel);
            total++;
            assert (obs === e.val)
            else begin
                bad++;
                $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
            end
        end
    endtask

    // Called at a negedge; returns at a negedge with the press fully processed.
    task automatic press(input logic [3:0] code, input int hold);
        kc = code;
        kv = 1'b1;
        repeat (hold) @(negedge clk);
        kv = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    int c0;
    int s0;

    initial begin
        rst  = 1'b1;
        kv   = 1'b0;
        kc   = 4'd0;
        sel3 = 1'b0;
        #2;
        exp_push("rst_mode", S_MODE, 0);
        exp_push("rst_x", S_X, 0);
        exp_push("rst_y", S_Y, 0);
        exp_push("rst_op", S_OP, 0);
        exp_push("rst_ledx", S_LX, 0);
        exp_push("rst_ledy", S_LY, 0);
        exp_push("rst_swc", S_SWC, 0);
        exp_push("rst_cs", S_CS, 0);
        exp_push("rst_swv", S_SWVL, 0);
        exp_push("rst_mode3", S_MODE3, 0);
        drain();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // T1: basic calculation flow, with first-press latency
        c0 = calc_cnt;
        s0 = swv_cnt;
        kc = 4'd14;
        kv = 1'b1;
        @(negedge clk);
        exp_push("lat_edgeN", S_MODE, 0);
        drain();
        @(negedge clk);
        exp_push("lat_edgeN1", S_MODE, 1);
        drain();
        @(negedge clk);
        kv = 1'b0;
        repeat (2) @(negedge clk);
        press(4'd4, 3);
        press(4'd2, 3);
        exp_push("t1_x42", S_X, 42);
        exp_push("t1_mode1", S_MODE, 1);
        drain();
        press(4'd14, 3);
        exp_push("t1_mode2", S_MODE, 2);
        exp_push("t1_ledx", S_LX, 1);
        drain();
        press(4'd12, 3);
        exp_push("t1_op_mul", S_OP, 2);
        drain();
        press(4'd10, 3);
        press(4'd7, 3);
        exp_push("t1_op_add", S_OP, 0);
        exp_push("t1_y7", S_Y, 7);
        drain();
        press(4'd14, 3);
        exp_push("t1_mode3", S_MODE, 3);
        exp_push("t1_ledy", S_LY, 1);
        exp_push("t1_ledx_held", S_LX, 1);
        exp_push("t1_calc_once", S_CALC, c0 + 1);
        exp_push("t1_no_swv", S_SWV, s0);
        drain();
        press(4'd5, 3);
        exp_push("res_digit_x", S_X, 42);
        exp_push("res_digit_y", S_Y, 7);
        exp_push("res_digit_mode", S_MODE, 3);
        drain();
        press(4'd15, 3);
        exp_push("res_clr_mode", S_MODE, 0);
        exp_push("res_clr_ledx", S_LX, 0);
        exp_push("res_clr_ledy", S_LY, 0);
        exp_push("res_clr_xkept", S_X, 42);
        drain();

        // T3: held key in STOPWATCH forwards exactly once
        s0 = swv_cnt;
        press(4'd12, 50);
        exp_push("t3_swc", S_SWC, 12);
        exp_push("t3_swv_once", S_SWV, s0 + 1);
        exp_push("t3_mode", S_MODE, 0);
        drain();

        // T4: CLEAR / ENTER corner cases
        press(4'd14, 3);
        press(4'd3, 3);
        exp_push("t4_x3", S_X, 3);
        drain();
        press(4'd15, 3);
        exp_push("t4_clr_x", S_X, 0);
        exp_push("t4_clr_mode", S_MODE, 1);
        drain();
        press(4'd15, 3);
        exp_push("t4_clr2_mode", S_MODE, 0);
        drain();
        press(4'd14, 3);
        press(4'd14, 3);
        exp_push("t4_enter_cnt0", S_MODE, 1);
        exp_push("t4_enter_cnt0_led", S_LX, 0);
        drain();
        press(4'd5, 3);
        press(4'd14, 3);
        press(4'd15, 3);
        exp_push("t4_ybk_mode", S_MODE, 1);
        exp_push("t4_ybk_ledx", S_LX, 0);
        drain();
        press(4'd6, 3);
        exp_push("t4_xlocked", S_X, 5);
        drain();
        press(4'd14, 3);
        exp_push("t4_reconfirm", S_MODE, 2);
        exp_push("t4_reconfirm_led", S_LX, 1);
        drain();
        press(4'd15, 3);
        press(4'd15, 3);
        exp_push("t4_unlock_x", S_X, 0);
        exp_push("t4_unlock_mode", S_MODE, 1);
        drain();
        press(4'd15, 3);

        // T2: digit saturation
        press(4'd14, 3);
        press(4'd9, 3);
        press(4'd9, 3);
        press(4'd5, 3);
        exp_push("t2_x99", S_X, 99);
        drain();
        press(4'd15, 3);
        press(4'd15, 3);
        sel3 = 1'b1;
        press(4'd14, 3);
        press(4'd9, 3);
        press(4'd9, 3);
        press(4'd9, 3);
        press(4'd9, 3);
        exp_push("t2_mode3", S_MODE3, 1);
        exp_push("t2_x999", S_X3, 999);
        drain();
        sel3 = 1'b0;

        // T5: idle timeout
        exp_push("t5_start", S_MODE, 0);
        drain();
        press(4'd14, 3);
        repeat (96) @(negedge clk);
        exp_push("t5_99clk", S_MODE, 1);
        drain();
        @(negedge clk);
        exp_push("t5_100clk", S_MODE, 0);
        drain();
        press(4'd14, 3);
        repeat (95) @(negedge clk);
        press(4'd3, 3);
        exp_push("t5_keywins_mode", S_MODE, 1);
        exp_push("t5_keywins_x", S_X, 3);
        drain();
        repeat (96) @(negedge clk);
        exp_push("t5_restart_99", S_MODE, 1);
        drain();
        @(negedge clk);
        exp_push("t5_restart_100", S_MODE, 0);
        exp_push("t5_xkept", S_X, 3);
        drain();

        // T6: asynchronous reset mid-entry, key held through release
        press(4'd14, 3);
        press(4'd1, 3);
        press(4'd2, 3);
        press(4'd13, 3);
        press(4'd14, 3);
        exp_push("t6_pre_mode", S_MODE, 2);
        exp_push("t6_pre_x", S_X, 12);
        exp_push("t6_pre_op", S_OP, 3);
        drain();
        s0 = swv_cnt;
        kc = 4'd5;
        kv = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        exp_push("t6_rst_mode", S_MODE, 0);
        exp_push("t6_rst_x", S_X, 0);
        exp_push("t6_rst_op", S_OP, 0);
        exp_push("t6_rst_ledx", S_LX, 0);
        exp_push("t6_rst_swc", S_SWC, 0);
        drain();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        kv = 1'b0;
        repeat (2) @(negedge clk);
        exp_push("t6_held_swc", S_SWC, 5);
        exp_push("t6_held_once", S_SWV, s0 + 1);
        exp_push("t6_held_mode", S_MODE, 0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
